// File: rtl/phase_clkgen.sv
// Multi-phase clock/strobe generator: one frame counter, N_CH rise/fall windows,
// shadowed config applied at the frame wrap, hold and single-frame step.

module phase_ch #(
  parameter int              CNT_W = 8,
  parameter logic [CNT_W-1:0] DEF_R = '0,
  parameter logic [CNT_W-1:0] DEF_F = '0
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             adv,
  input  logic             wrap,
  input  logic             we,
  input  logic [CNT_W-1:0] rise_in,
  input  logic [CNT_W-1:0] fall_in,
  input  logic [CNT_W-1:0] cnt,
  output logic             ph
);
  logic [CNT_W-1:0] sh_r, sh_f, act_r, act_f;
  logic             win;

  always_comb begin
    win = 1'b0;
    if (act_r < act_f)      win = (cnt >= act_r) && (cnt < act_f);
    else if (act_r > act_f) win = (cnt >= act_r) || (cnt < act_f);
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      sh_r  <= DEF_R;
      sh_f  <= DEF_F;
      act_r <= DEF_R;
      act_f <= DEF_F;
      ph    <= 1'b0;
    end else begin
      if (we) begin
        sh_r <= rise_in;
        sh_f <= fall_in;
      end
      // a write landing on the wrap edge takes effect in the new frame
      if (wrap) begin
        act_r <= we ? rise_in : sh_r;
        act_f <= we ? fall_in : sh_f;
      end
      if (adv) ph <= win;
    end
  end
endmodule

module phase_clkgen #(
  parameter int                       CNT_W      = 8,
  parameter int                       N_CH       = 4,
  parameter logic [CNT_W-1:0]         DEF_PERIOD = 8'd99,
  parameter logic [N_CH*CNT_W-1:0]    DEF_RISE   = {8'd0, 8'd90, 8'd5, 8'd31},
  parameter logic [N_CH*CNT_W-1:0]    DEF_FALL   = {8'd50, 8'd0, 8'd11, 8'd70},
  parameter int                       SEL_W      = $clog2(N_CH+1)
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [CNT_W-1:0] cfg_rise,
  input  logic [CNT_W-1:0] cfg_fall,
  output logic [N_CH-1:0]  ph_out,
  output logic             cyc_start,
  output logic [CNT_W-1:0] cnt,
  output logic             cfg_pending
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STEP = 1'b1;

  logic [0:0]       state;
  logic             stepping, adv, wrap, per_we, cfg_ok;
  logic [CNT_W-1:0] per_act, per_sh, per_in;

  assign stepping = (state == STEP);
  assign adv      = run | stepping;
  // >= rather than == so a too-small period can never let the counter run away
  assign wrap     = adv && (cnt >= per_act);
  assign per_we   = cfg_we && (cfg_sel == SEL_W'(N_CH));
  assign cfg_ok   = cfg_we && (cfg_sel <= SEL_W'(N_CH));
  assign per_in   = (cfg_rise == '0) ? CNT_W'(1) : cfg_rise;

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      cyc_start   <= 1'b0;
      cfg_pending <= 1'b0;
      state       <= IDLE;
      per_act     <= DEF_PERIOD;
      per_sh      <= DEF_PERIOD;
    end else begin
      if (adv) begin
        cnt       <= wrap ? '0 : cnt + CNT_W'(1);
        cyc_start <= wrap;
      end else begin
        cyc_start <= 1'b0;
      end
      if (per_we) per_sh  <= per_in;
      if (wrap)   per_act <= per_we ? per_in : per_sh;
      cfg_pending <= wrap ? 1'b0 : (cfg_pending | cfg_ok);
      case (state)
        IDLE:    if (step && !run) state <= STEP;
        default: if (wrap)         state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    phase_ch #(
      .CNT_W (CNT_W),
      .DEF_R (DEF_RISE[i*CNT_W +: CNT_W]),
      .DEF_F (DEF_FALL[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk_100M (clk_100M),
      .rst      (rst),
      .adv      (adv),
      .wrap     (wrap),
      .we       (cfg_we && (cfg_sel == SEL_W'(i))),
      .rise_in  (cfg_rise),
      .fall_in  (cfg_fall),
      .cnt      (cnt),
      .ph       (ph_out[i])
    );
  end
endmodule

// File: doc/phase_clkgen.md
Name: phase_clkgen

Overview:
- Parametrised multi-phase clock/strobe generator for the multi-cycle RISC-V core. It generalises the fixed alu/fetch/reg/ram divider into N_CH channels.
- A single frame counter runs at the system clock. Each channel output is a window (rise/fall compare) within the frame.
- Rise, fall and period are runtime-reprogrammable with glitch-free, frame-boundary updates. The block supports hold (stall) and single-frame step for debug.
- Sits between clk_100M and the core stage enables.

Parameters:
- CNT_W, 8, width of frame counter and all compare values.
- N_CH, 4, number of phase channels.
- DEF_PERIOD, 99, reset terminal count; frame length = terminal count + 1 cycles.
- DEF_RISE, {8'd0,8'd90,8'd5,8'd31}, packed N_CH*CNT_W reset rise values; ch0 in LSBs.
- DEF_FALL, {8'd50,8'd0,8'd11,8'd70}, packed N_CH*CNT_W reset fall values.
- SEL_W, $clog2(N_CH+1), config select width.

Ports:
- clk_100M  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = frame counter advances; 0 = hold (stall).
- step  in  1  single-cycle pulse; with run=0, advance to end of current frame.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  SEL_W  0..N_CH-1 selects channel rise/fall; N_CH selects period; other values are ignored.
- cfg_rise  in  CNT_W  rise value, or terminal count when cfg_sel==N_CH.
- cfg_fall  in  CNT_W  fall value; unused for period writes.
- ph_out  out  N_CH  registered phase outputs.
- cyc_start  out  1  one-cycle pulse on frame wrap.
- cnt  out  CNT_W  current frame count.
- cfg_pending  out  1  shadow config written but not yet applied.

Behaviour:
- Reset (async, immediate):
  - cnt=0, ph_out=0, cyc_start=0, cfg_pending=0, stepping=0.
  - Active and shadow registers load DEF_PERIOD, DEF_RISE and DEF_FALL.
- Advance condition: adv = run | stepping.
  - adv=0: cnt, ph_out and cyc_start hold; cyc_start is forced to 0.
- Counter:
  - When adv=1 and cnt==period_act, cnt goes to 0 (wrap).
  - When adv=1 otherwise, cnt goes to cnt+1.
  - If period_act < cnt (period shrink cannot occur mid-frame; guard only), the counter also wraps.
- cyc_start is registered: 1 in the cycle after a wrap edge, otherwise 0.
- Channel window, evaluated on the current cnt and registered, so ph_out lags cnt by 1 cycle:
  - rise<fall: high when rise <= cnt < fall.
  - rise>fall: high when cnt >= rise or cnt < fall (wrap window).
  - rise==fall: constantly 0.
- Config path:
  - cfg_we writes shadow registers and sets cfg_pending.
  - A period write of 0 is stored as 1; minimum frame length is 2.
  - At the wrap edge (adv=1, cnt==period_act), active <= shadow and cfg_pending clears.
  - A write in the same cycle as the wrap is included in the applied value, and cfg_pending ends 0.
- Step FSM, states IDLE and STEP:
  - IDLE to STEP on step=1 while run=0.
  - STEP to IDLE on the wrap edge; cnt then holds at 0.
  - step during STEP, or while run=1, is ignored.
  - run rising during STEP: counting continues and the FSM returns to IDLE at the wrap.
- Reset mid-frame or mid-step aborts immediately to reset values; pending writes are lost.

Test Plan:
- Release reset, run=1, defaults:
  - ph_out[0] high for 39 cycles, from the cycle after cnt==31 through the cycle after cnt==69.
  - ph_out[1] high 6 cycles.
  - ph_out[2] high for cnt 90..99 (wrap window, fall=0).
  - cyc_start pulses every 100 cycles.
- Hold: run=0 at cnt=50 for 20 cycles.
  - cnt stays 50; ph_out constant (ph_out[3]=1, ph_out[0]=1); no cyc_start.
  - Resume continues at 51.
- Period reprogram: cfg_sel=4, cfg_rise=49 written at cnt=20.
  - cfg_pending=1 until the wrap at 99; current frame stays 100 cycles.
  - Subsequent cyc_start spacing is 50 cycles.
  - Writing 0 gives spacing 2.
- Channel edit: at cnt=10, write ch0 rise=60 fall=10.
  - ph_out[0] keeps the old window this frame.
  - Next frame it is high for cnt 60..99 and 0..9.
  - rise=fall=5 gives ph_out[0]=0 for the whole frame.
- Step: run=0, step pulse at cnt=40.
  - Counts to 99, wraps, holds at cnt=0 with exactly one cyc_start.
  - A second step pulse during the step has no effect.
- Reset: assert rst at cnt=60 after a pending write.
  - All outputs go to 0 without a clock edge.
  - After release, timing matches the default-config scenario.
